// File: rtl/instruction_fetch_unit_if.sv
// Bus between the instruction fetch unit, the byte-wide program memory and the
// instruction register stage.
interface instruction_fetch_unit_if;
  logic        Start;
  logic        PcLoad;
  logic [15:0] PcIn;
  logic [7:0]  MemData;
  logic        Ack;
  logic [15:0] MemAddr;
  logic        MemRd;
  logic [15:0] IR;
  logic        IRValid;
  logic [15:0] PC;
  logic        Busy;

  modport master (
    input  Start, PcLoad, PcIn, MemData, Ack,
    output MemAddr, MemRd, IR, IRValid, PC, Busy
  );

  modport slave (
    output Start, PcLoad, PcIn, MemData, Ack,
    input  MemAddr, MemRd, IR, IRValid, PC, Busy
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: reads two consecutive bytes at PC and PC+1 and presents them
// as one 16-bit instruction (low byte first) behind a valid/ack handshake.
module instruction_fetch_unit (
  input  logic                            Clock,
  input  logic                            Reset,
  instruction_fetch_unit_if.master        bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_LO   = 3'd1;
  localparam logic [2:0] RD_HI   = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] VALID   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        mem_rd_q, mem_rd_d;
  logic        busy_q, busy_d;

  // Next-state, PC and IR byte capture; PcLoad overrides everything but reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        if (bus.PcLoad) begin
          pc_d = bus.PcIn;
        end else if (bus.Start) begin
          state_d = RD_LO;
        end else begin
          state_d = IDLE;
        end
      end
      RD_LO: begin
        if (bus.PcLoad) begin
          pc_d    = bus.PcIn;
          state_d = IDLE;
        end else begin
          pc_d    = pc_q + 16'd1;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        if (bus.PcLoad) begin
          pc_d    = bus.PcIn;
          state_d = IDLE;
        end else begin
          ir_d[7:0] = bus.MemData;
          pc_d      = pc_q + 16'd1;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.PcLoad) begin
          pc_d    = bus.PcIn;
          state_d = IDLE;
        end else begin
          ir_d[15:8] = bus.MemData;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (bus.PcLoad) begin
          pc_d    = bus.PcIn;
          state_d = IDLE;
        end else if (bus.Ack && bus.Start) begin
          state_d = RD_LO;
        end else if (bus.Ack) begin
          state_d = IDLE;
        end else begin
          state_d = VALID;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered, so decode them from the upcoming state.
    ir_valid_d = (state_d == VALID);
    mem_rd_d   = (state_d == RD_LO) || (state_d == RD_HI);
    busy_d     = (state_d == RD_LO) || (state_d == RD_HI) || (state_d == WAIT_HI);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      pc_q       <= 16'h0000;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.MemAddr = pc_q;
  assign bus.PC      = pc_q;
  assign bus.IR      = ir_q;
  assign bus.IRValid = ir_valid_q;
  assign bus.MemRd   = mem_rd_q;
  assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations
// followed by random stimulus checked every cycle against a transaction model.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus.master)
  );

  logic [7:0] mem [0:65535];
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // One-cycle-latency memory; garbage on the data bus when not reading.
  always @(posedge clk) bus.MemData <= bus.MemRd ? mem[bus.MemAddr] : 8'($urandom);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is "cycles left until the word is complete".
  int          m_left = 0;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ir = 16'h0000;
  logic        m_valid = 1'b0;
  logic [7:0]  m_lo = 8'h00;
  logic [7:0]  m_hi = 8'h00;
  logic [15:0] m_a1;
  bit          m_go;

  initial forever begin
    @(posedge clk or negedge rst_n);
    m_go = 1'b0;
    if (!rst_n) begin
      m_left = 0; m_pc = 16'h0000; m_ir = 16'h0000; m_valid = 1'b0;
    end else if (bus.PcLoad) begin
      m_pc = bus.PcIn; m_left = 0; m_valid = 1'b0;
    end else if (m_left > 0) begin
      if (m_left >= 2) m_pc = m_pc + 16'd1;
      if (m_left == 2) m_ir[7:0] = m_lo;
      if (m_left == 1) begin m_ir[15:8] = m_hi; m_valid = 1'b1; end
      m_left = m_left - 1;
    end else if (m_valid) begin
      if (bus.Ack) begin
        m_valid = 1'b0;
        m_go = bus.Start;
      end
    end else begin
      m_go = bus.Start;
    end
    if (m_go) begin
      m_left = 3;
      m_a1 = m_pc + 16'd1;
      m_lo = mem[m_pc];
      m_hi = mem[m_a1];
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("PC", bus.PC, m_pc);
      chk("MemAddr", bus.MemAddr, m_pc);
      chk("IR", bus.IR, m_ir);
      chk("IRValid", 16'(bus.IRValid), 16'(m_valid));
      chk("MemRd", 16'(bus.MemRd), 16'((m_left == 3) || (m_left == 2)));
      chk("Busy", 16'(bus.Busy), 16'(m_left != 0));
    end
  end

  task automatic pulse_start_and_wait();
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] got_ir [0:1];
  logic [15:0] got_pc;
  int          got_cyc [0:1];
  int          n_got;
  logic [15:0] held_ir;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.Start = 1'b0; bus.PcLoad = 1'b0; bus.PcIn = 16'h0000; bus.Ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_PC", bus.PC, 16'h0000);
    chk("rst_MemAddr", bus.MemAddr, 16'h0000);
    chk("rst_IR", bus.IR, 16'h0000);
    chk("rst_flags", {13'd0, bus.IRValid, bus.MemRd, bus.Busy}, 16'h0000);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic fetch
    mem[0] = 8'h34; mem[1] = 8'h12;
    bus.Start = 1'b1;
    @(negedge clk); bus.Start = 1'b0;
    chk("basic_rd0", {bus.MemAddr[14:0], bus.MemRd}, {15'h0000, 1'b1});
    @(negedge clk);
    chk("basic_rd1", {bus.MemAddr[14:0], bus.MemRd}, {15'h0001, 1'b1});
    @(negedge clk);
    chk("basic_wait", {14'd0, bus.MemRd, bus.IRValid}, 16'h0000);
    @(negedge clk);
    chk("basic_IR", bus.IR, 16'h1234);
    chk("basic_valid", 16'(bus.IRValid), 16'h0001);
    chk("basic_PC", bus.PC, 16'h0002);
    bus.Ack = 1'b1; @(negedge clk); bus.Ack = 1'b0;

    // Back-to-back fetches
    bus.PcLoad = 1'b1; bus.PcIn = 16'h0000; @(negedge clk); bus.PcLoad = 1'b0;
    mem[2] = 8'hCD; mem[3] = 8'hAB;
    n_got = 0; got_pc = 16'h0000;
    bus.Start = 1'b1; bus.Ack = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.IRValid) begin
        got_ir[n_got] = bus.IR; got_cyc[n_got] = c; got_pc = bus.PC;
        n_got++;
        if (n_got == 2) break;
      end
    end
    bus.Start = 1'b0;
    @(negedge clk); bus.Ack = 1'b0;
    chk("b2b_count", 16'(n_got), 16'd2);
    if (n_got == 2) begin
      chk("b2b_IR0", got_ir[0], 16'h1234);
      chk("b2b_IR1", got_ir[1], 16'hABCD);
      chk("b2b_gap", 16'(got_cyc[1] - got_cyc[0]), 16'd4);
      chk("b2b_PC", got_pc, 16'h0004);
    end

    // Wrap-around
    mem[16'hFFFF] = 8'h78; mem[0] = 8'h56;
    bus.PcLoad = 1'b1; bus.PcIn = 16'hFFFF; @(negedge clk); bus.PcLoad = 1'b0;
    pulse_start_and_wait();
    chk("wrap_IR", bus.IR, 16'h5678);
    chk("wrap_PC", bus.PC, 16'h0001);
    bus.Ack = 1'b1; @(negedge clk); bus.Ack = 1'b0;

    // Abort during RD_HI, then fetch from the new PC
    bus.Start = 1'b1; @(negedge clk); bus.Start = 1'b0;
    @(negedge clk);
    bus.PcLoad = 1'b1; bus.PcIn = 16'h0040; @(negedge clk); bus.PcLoad = 1'b0;
    chk("abort_flags", {13'd0, bus.IRValid, bus.MemRd, bus.Busy}, 16'h0000);
    chk("abort_PC", bus.PC, 16'h0040);
    mem[16'h0040] = 8'hEF; mem[16'h0041] = 8'hBE;
    pulse_start_and_wait();
    chk("abort_IR", bus.IR, 16'hBEEF);
    chk("abort_PC2", bus.PC, 16'h0042);

    // Hold in VALID without Ack
    held_ir = bus.IR;
    repeat (10) begin
      @(negedge clk);
      chk("hold_IR", bus.IR, 16'hBEEF);
      chk("hold_valid", 16'(bus.IRValid), 16'h0001);
    end

    // PcLoad wins over Ack+Start in VALID
    bus.Ack = 1'b1; bus.Start = 1'b1; bus.PcLoad = 1'b1; bus.PcIn = 16'h0100;
    @(negedge clk);
    bus.Ack = 1'b0; bus.Start = 1'b0; bus.PcLoad = 1'b0;
    chk("simul_flags", {13'd0, bus.IRValid, bus.MemRd, bus.Busy}, 16'h0000);
    chk("simul_PC", bus.PC, 16'h0100);
    @(negedge clk);
    chk("simul_noread", 16'(bus.MemRd), 16'h0000);

    // Reset mid-fetch takes effect before the next edge
    bus.Start = 1'b1; @(negedge clk); bus.Start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_PC", bus.PC, 16'h0000);
    chk("mrst_IR", bus.IR, 16'h0000);
    chk("mrst_flags", {13'd0, bus.IRValid, bus.MemRd, bus.Busy}, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle", 16'(bus.Busy), 16'h0000);
    pulse_start_and_wait();
    chk("mrst_IR2", bus.IR, {mem[1], mem[0]});
    chk("mrst_IR2_lit", bus.IR, 16'h1256);
    chk("mrst_PC2", bus.PC, 16'h0002);
    bus.Ack = 1'b1; @(negedge clk); bus.Ack = 1'b0;

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      bus.Start  = 1'($urandom_range(0, 1));
      bus.Ack    = 1'($urandom_range(0, 1));
      bus.PcLoad = ($urandom_range(0, 15) == 0);
      bus.PcIn   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                               : 16'($urandom);
      rst_n      = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.PcLoad = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequencer that sits directly upstream of the 16-bit instruction register in the datapath. It owns the program counter, reads two consecutive bytes from the 8-bit-wide memory, and assembles them into one 16-bit instruction word. It presents that word with a valid/ack handshake to the register stage, which latches it as a full 16-bit load. It also accepts an external PC load for branches and jumps.

## Interface
- Parameters: none; PC, address and instruction are fixed at 16 bits, memory data at 8 bits.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset. Reset is asserted when Reset = 0.
- Start  in  1  request a fetch; sampled in IDLE and in VALID on the Ack cycle.
- PcLoad  in  1  load PC from PcIn; aborts any fetch in progress.
- PcIn  in  16  new PC value.
- MemData  in  8  memory read data, valid the cycle after MemRd=1.
- Ack  in  1  consumer accepts IR; meaningful only while IRValid=1.
- MemAddr  out  16  memory address; combinationally equal to PC.
- MemRd  out  1  memory read strobe.
- IR  out  16  assembled instruction; low byte at PC, high byte at PC+1.
- IRValid  out  1  IR holds a complete, unconsumed instruction.
- PC  out  16  current program counter.
- Busy  out  1  fetch in progress (states RD_LO, RD_HI, WAIT_HI).

## Operation
- State machine states: IDLE, RD_LO, RD_HI, WAIT_HI, VALID.
- **IDLE:** MemRd=0.
  - PcLoad=1 → PC←PcIn, stay IDLE.
  - Else Start=1 → RD_LO.
- **RD_LO:** MemRd=1 (address = PC); PC←PC+1; → RD_HI.
- **RD_HI:** MemRd=1 (address = PC, i.e. the incremented value); IR[7:0]←MemData; PC←PC+1; → WAIT_HI.
- **WAIT_HI:** MemRd=0; IR[15:8]←MemData; → VALID.
- **VALID:** IRValid=1; IR is held stable.
  - PcLoad=1 → PC←PcIn, IRValid cleared, → IDLE. This applies whether or not Ack=1, and there is no restart that cycle.
  - Else Ack=1 and Start=1 → RD_LO (back-to-back fetch).
  - Else Ack=1 → IDLE.
  - Else stay in VALID.
- **PcLoad in RD_LO, RD_HI or WAIT_HI:**
  - PC←PcIn; → IDLE; MemRd=0 from the next cycle.
  - IR bytes not yet captured are discarded; IR holds whatever partial content it has.
  - IRValid stays 0.
- **PC arithmetic:** modulo 2^16; 16'hFFFF + 1 = 16'h0000, with no flag raised.
- **Priority within a cycle:** Reset > PcLoad > Start/Ack.
- **Ack outside VALID:** ignored.

## Timing
- **Reset values** (immediate on Reset=0, independent of Clock):
  - state = IDLE.
  - PC = 16'h0000 (so MemAddr = 16'h0000).
  - IR = 16'h0000.
  - IRValid = 0, MemRd = 0, Busy = 0.
- **Reset mid-fetch:** returns to the above values at once; the fetch is not resumed after release.
- **Fetch latency:** with Start sampled at edge E0 in IDLE:
  - RD_LO during cycle 1.
  - RD_HI during cycle 2.
  - WAIT_HI during cycle 3.
  - IRValid=1 from edge E3 onward.
- **Memory:** has one-cycle read latency; MemData is captured at the end of the cycle following each MemRd=1 cycle.
- **Throughput:** one instruction per 4 cycles when Ack and Start are both held high.
- **Handshake:** the consumer loads IR on the cycle where IRValid=1 and Ack=1. IR does not change while IRValid=1.
- **PC after a completed fetch:** start PC + 2.

## Test plan
- **Reset:** drive Reset=0 mid-sequence → all outputs are at their reset values immediately (before the next Clock edge); after release, Start=1 fetches from address 0.
- **Basic fetch:** mem[0]=8'h34, mem[1]=8'h12, pulse Start → MemRd high for exactly 2 cycles at addresses 0 then 1; IR=16'h1234 and IRValid=1 at the 3rd edge; PC=16'h0002.
- **Back-to-back:** mem[0..3]=34,12,CD,AB, with Start and Ack held at 1 → IR=16'h1234 then 16'hABCD, four cycles apart; IRValid drops for 3 cycles between them; PC=4.
- **Wrap-around:** PcLoad with PcIn=16'hFFFF, mem[FFFF]=8'h78, mem[0]=8'h56 → IR=16'h5678; PC=16'h0001.
- **Abort:** PcLoad with PcIn=16'h0040 during RD_HI → IDLE next cycle; MemRd=0; IRValid stays 0; PC=16'h0040. A following Start fetches from 16'h0040.
- **Simultaneous events in VALID:** Ack=1, Start=1 and PcLoad=1 with PcIn=16'h0100 → IRValid cleared; state IDLE; PC=16'h0100; no MemRd that cycle. Also: Ack held at 0 for 10 cycles → IR stable and IRValid stays 1 throughout.
